clock_monitor: RTL



---
 rtl/clock_monitor_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/clock_monitor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared FSM encoding, synchronizer depth and period helper for clock_monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Nominal monitored period in system clock cycles (integer division).
  function automatic int expected_period(input int sys_hz, input int mon_hz);
    return sys_hz / mon_hz;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, plus one history flop
// producing single-cycle rise and fall pulses in the clk domain.
module sync_edge_detect
  import clock_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      hist    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
      hist    <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_ff[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist;
  assign fall     = ~sync_out & hist;

endmodule

// File: rtl/clock_monitor.sv
// Measures period/high time of mon_clk_in in the clk domain, declares lock and
// flags timeout. Define CLOCK_MONITOR_DUTY_CHECK_EN to add duty checking and duty_error.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int SYS_CLK_FREQUENCY = 100_000_000,
  parameter int MON_CLK_FREQUENCY = 10_000_000,
  parameter int TOLERANCE_CYCLES  = 1,
  parameter int LOCK_COUNT        = 4,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mon_clk_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] period_count,
  output logic [COUNT_WIDTH-1:0] high_count,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   timeout,
  output logic [7:0]             error_count
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  ,
  output logic                   duty_error
`endif
);

  localparam int EXPECTED_PERIOD = expected_period(SYS_CLK_FREQUENCY, MON_CLK_FREQUENCY);
  localparam int GOOD_WIDTH      = $clog2(LOCK_COUNT + 1);

  localparam logic [COUNT_WIDTH-1:0] EXP_C  = COUNT_WIDTH'(EXPECTED_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] TOL_C  = COUNT_WIDTH'(TOLERANCE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] TMO_C  = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [GOOD_WIDTH-1:0]  LOCK_C = GOOD_WIDTH'(LOCK_COUNT);

  if (EXPECTED_PERIOD < 4 ||
      longint'(EXPECTED_PERIOD) + longint'(TOLERANCE_CYCLES) >= (longint'(1) << COUNT_WIDTH))
  begin : g_cfg_check
    $error("clock_monitor: EXPECTED_PERIOD out of range for COUNT_WIDTH");
  end

  // Unsigned distance without wrap, compared against the tolerance.
  function automatic logic within_tol(input logic [COUNT_WIDTH-1:0] value,
                                      input logic [COUNT_WIDTH-1:0] target);
    logic [COUNT_WIDTH-1:0] diff;
    diff = (value >= target) ? value - target : target - value;
    return diff <= TOL_C;
  endfunction

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] per_cnt, hi_cnt;
  logic [GOOD_WIDTH-1:0]  good_cnt, good_cnt_inc;
  logic                   sync, rise, unused_fall;
  logic                   eval, tmo_hit, tmo_reached;
  logic                   period_ok, good;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (mon_clk_in),
    .sync_out (sync),
    .rise     (rise),
    .fall     (unused_fall)
  );

  assign period_ok    = within_tol(per_cnt, EXP_C);
  assign tmo_reached  = per_cnt >= TMO_C;
  assign good_cnt_inc = (good_cnt == LOCK_C) ? good_cnt : good_cnt + GOOD_WIDTH'(1);

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic [COUNT_WIDTH-1:0] HALF_C = COUNT_WIDTH'(EXPECTED_PERIOD / 2);
  logic duty_ok;
  assign duty_ok = within_tol(hi_cnt, HALF_C);
  assign good    = period_ok & duty_ok;
`else
  assign good    = period_ok;
`endif

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    eval       = 1'b0;
    tmo_hit    = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = ARM;
        ARM: begin
          // First rise only aligns the counters; the partial period is dropped.
          if (rise)             state_next = MEASURE;
          else if (tmo_reached) tmo_hit    = 1'b1;
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            eval = 1'b1;
            if (!good)                                         state_next = MEASURE;
            else if (state == LOCKED || good_cnt_inc == LOCK_C) state_next = LOCKED;
          end else if (tmo_reached) begin
            tmo_hit    = 1'b1;
            state_next = ARM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: all state, including counters, is reset synchronously so a mid-run
  // rst leaves no partial measurement behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      good_cnt     <= '0;
      period_count <= '0;
      high_count   <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      error_count  <= '0;
    end else begin
      state        <= state_next;
      period_valid <= eval;
      if (!enable || state == IDLE) begin
        per_cnt  <= '0;
        hi_cnt   <= '0;
        good_cnt <= '0;
      end else begin
        if (rise) begin
          // sync is already high in the rise cycle, so it counts toward high time.
          per_cnt <= COUNT_WIDTH'(1);
          hi_cnt  <= COUNT_WIDTH'(1);
        end else begin
          if (!(&per_cnt))         per_cnt <= per_cnt + COUNT_WIDTH'(1);
          if (sync && !(&hi_cnt))  hi_cnt  <= hi_cnt + COUNT_WIDTH'(1);
        end
        if (eval) begin
          period_count <= per_cnt;
          high_count   <= hi_cnt;
          if (good) begin
            good_cnt <= good_cnt_inc;
          end else begin
            good_cnt <= '0;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end
        end
        if (tmo_hit) begin
          timeout  <= 1'b1;
          good_cnt <= '0;
        end
      end
    end
  end

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) duty_error <= 1'b0;
    else     duty_error <= eval & period_ok & ~duty_ok;
  end
`endif

  assign locked = (state == LOCKED);

endmodule
